// File: rtl/link_state_bus_scan.sv
// link_state_bus_scan: snapshots a wide link-state bus on request and
// streams it out one word per valid/ready transfer.
//
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   sta_bus       - NUM_PH*NUM_LINK*2 words; phase 0 / link 1 high at top
//   snap_req      - capture sta_bus and start a scan (ignored while busy)
//   busy          - high from capture through the DONE cycle
//   out_valid/out_ready - word stream handshake
//   out_ph/out_link/out_hl/out_data - tags and value of current word
//   done          - one-cycle pulse when the scan completes
//   ovr_cnt       - saturating count of ignored snap_req pulses
//
// Build option: LINK_STATE_CHG_ONLY_EN streams only words that differ
// from the previous completed scan; unchanged words are skipped.
module link_state_bus_scan #(
  parameter int NUM_PH   = 3,
  parameter int NUM_LINK = 24,
  parameter int WORD_W   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PH*NUM_LINK*2*WORD_W-1:0] sta_bus,
  input  logic                               snap_req,
  output logic                               busy,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [3:0]                         out_ph,
  output logic [7:0]                         out_link,
  output logic                               out_hl,
  output logic [WORD_W-1:0]                  out_data,
  output logic                               done,
  output logic [7:0]                         ovr_cnt
);

  localparam int T  = NUM_PH * NUM_LINK * 2;
  localparam int BW = T * WORD_W;
  localparam int IW = $clog2(T + 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   snap_q, snap_d;
  logic [7:0]      ovr_q, ovr_d;
  logic [WORD_W-1:0] cur_w;
  logic            present;
  logic            adv;
  logic            last;
  int              idx_i;
  int              ph_i;
  int              link_i;

`ifdef LINK_STATE_CHG_ONLY_EN
  logic [BW-1:0]     prev_q, prev_d;
  logic [WORD_W-1:0] prev_w;
`endif

  // Word i sits i words below the top of the snapshot.
  always_comb begin
    idx_i  = int'(idx_q);
    ph_i   = idx_i / (2 * NUM_LINK);
    link_i = (idx_i % (2 * NUM_LINK)) / 2 + 1;
    cur_w  = snap_q[(T-1-idx_i)*WORD_W +: WORD_W];
    last   = (idx_q == IW'(T - 1));
`ifdef LINK_STATE_CHG_ONLY_EN
    prev_w  = prev_q[(T-1-idx_i)*WORD_W +: WORD_W];
    present = (state_q == SCAN) && (cur_w != prev_w);
`else
    present = (state_q == SCAN);
`endif
    // A skipped word advances without waiting for the consumer.
    adv = (state_q == SCAN) && (present ? out_ready : 1'b1);
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign ovr_cnt   = ovr_q;
  assign out_valid = present;
  assign out_ph    = present ? 4'(ph_i) : 4'd0;
  assign out_link  = present ? 8'(link_i) : 8'd0;
  assign out_hl    = present & ~idx_q[0];
  assign out_data  = present ? cur_w : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    ovr_d   = ovr_q;
    if (snap_req && (state_q != IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (snap_req) begin
          snap_d  = sta_bus;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (adv) begin
          if (last) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef LINK_STATE_CHG_ONLY_EN
  always_comb begin
    prev_d = prev_q;
    if (state_q == DONE) begin
      prev_d = snap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end
`endif

endmodule

// File: tb/tb_link_state_bus_scan.sv
// Bench for link_state_bus_scan: random buses checked against a
// word-list model, plus a small-parameter instance.
module tb_link_state_bus_scan;

  localparam int P  = 3;
  localparam int L  = 24;
  localparam int W  = 16;
  localparam int T  = P * L * 2;
  localparam int BW = T * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] sta_bus = '0;
  logic          snap_req = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, out_valid, out_hl, done;
  logic [3:0]    out_ph;
  logic [7:0]    out_link, ovr_cnt;
  logic [W-1:0]  out_data;

  logic [31:0]   sta_bus2 = '0;
  logic          snap_req2 = 1'b0;
  logic          out_ready2 = 1'b0;
  logic          busy2, out_valid2, out_hl2, done2;
  logic [3:0]    out_ph2;
  logic [7:0]    out_link2, ovr_cnt2, out_data2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int ph;
    int link;
    int hl;
    int data;
  } wd_t;

  wd_t           exp_q[$];
  logic [BW-1:0] prev_m = '0;

  link_state_bus_scan #(.NUM_PH(P), .NUM_LINK(L), .WORD_W(W)) dut (
    .clk(clk), .rst(rst), .sta_bus(sta_bus), .snap_req(snap_req),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_ph(out_ph), .out_link(out_link), .out_hl(out_hl),
    .out_data(out_data), .done(done), .ovr_cnt(ovr_cnt)
  );

  link_state_bus_scan #(.NUM_PH(1), .NUM_LINK(2), .WORD_W(8)) dut2 (
    .clk(clk), .rst(rst), .sta_bus(sta_bus2), .snap_req(snap_req2),
    .busy(busy2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_ph(out_ph2), .out_link(out_link2), .out_hl(out_hl2),
    .out_data(out_data2), .done(done2), .ovr_cnt(ovr_cnt2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = $urandom();
    return b;
  endfunction

  function automatic int word_at(input logic [BW-1:0] b, input int ph,
                                 input int link, input int hl);
    int k;
    k = (ph * L + link - 1) * 2 + (hl != 0 ? 0 : 1);
    return int'(b[BW-1-k*W -: W]);
  endfunction

  function automatic logic [BW-1:0] set_word(input logic [BW-1:0] b,
      input int ph, input int link, input int hl, input logic [W-1:0] v);
    int k;
    k = (ph * L + link - 1) * 2 + (hl != 0 ? 0 : 1);
    b[BW-1-k*W -: W] = v;
    return b;
  endfunction

  task automatic build_expected(input logic [BW-1:0] s);
    int v;
    exp_q.delete();
    for (int ph = 0; ph < P; ph++)
      for (int ln = 1; ln <= L; ln++)
        for (int h = 1; h >= 0; h--) begin
          v = word_at(s, ph, ln, h);
`ifdef LINK_STATE_CHG_ONLY_EN
          if (v == word_at(prev_m, ph, ln, h)) continue;
`endif
          exp_q.push_back('{ph, ln, h, v});
        end
  endtask

  // Called in the first SCAN cycle; drives out_ready and optional
  // snap_req pulses / bus changes until done is seen.
  task automatic collect(input logic [BW-1:0] s, input int stall_word,
      input int stall_len, input int rnd_pct, input int snap_every,
      input int snap_n, input int chg_at, output int n_words,
      output int done_cyc);
    wd_t         e;
    int          stall_left;
    logic        held;
    logic [28:0] hold_v;
    build_expected(s);
    n_words = 0;
    done_cyc = -1;
    stall_left = stall_len;
    held = 1'b0;
    hold_v = '0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_tags", {out_ph, out_link, out_hl, out_data}, hold_v);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      snap_req = (snap_n > 0) && (cyc % snap_every == 0) &&
                 (cyc / snap_every <= snap_n);
      if (cyc == chg_at) sta_bus = rand_bus();
      out_ready = ($urandom_range(99) >= rnd_pct);
      if (out_valid && n_words == stall_word && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      held = out_valid && !out_ready;
      hold_v = {out_ph, out_link, out_hl, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", {out_ph, out_link, out_hl, out_data}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("word", {out_ph, out_link, out_hl, out_data},
              {4'(e.ph), 8'(e.link), 1'(e.hl), 16'(e.data)});
        end
        n_words++;
      end
      tick();
    end
    snap_req = 1'b0;
    out_ready = 1'b0;
    chk("done_seen", done_cyc > 0, 1);
    chk("words_left", exp_q.size(), 0);
    if (done_cyc > 0) begin
      chk("done_busy", busy, 1);
      chk("done_valid", out_valid, 0);
      prev_m = s;
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
  endtask

  initial begin
    int nw;
    int dc;
    logic [BW-1:0] s;
    logic [7:0] bytes2 [4];

    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", ovr_cnt, 0);
    chk("rst_ph", out_ph, 0);
    chk("rst_link", out_link, 0);
    chk("rst_hl", out_hl, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy2", busy2, 0);

    snap_req = 1'b1;
    tick();
    chk("rst_prio_busy", busy, 0);
    snap_req = 1'b0;
    rst = 1'b0;
    tick();

    s = rand_bus();
    s = set_word(s, 0, 1, 1, 16'hA5A5);
    s = set_word(s, 2, 24, 0, 16'h0001);
    sta_bus = s;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("A_busy", busy, 1);
    chk("A_first", {out_valid, out_ph, out_link, out_hl, out_data},
        {1'b1, 4'd0, 8'd1, 1'b1, 16'hA5A5});
    collect(s, -1, 0, 0, 1, 0, 0, nw, dc);
    chk("A_done_cycle", dc, T + 1);
`ifndef LINK_STATE_CHG_ONLY_EN
    chk("A_words", nw, T);
`endif
    chk("A_ovr", ovr_cnt, 0);

    s = rand_bus();
    sta_bus = s;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    collect(s, 7, 5, 20, 10, 3, 15, nw, dc);
    chk("B_ovr", ovr_cnt, 3);

    s = rand_bus();
    s = set_word(s, 1, 5, 0, 16'h0000);
    sta_bus = s;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    collect(s, -1, 0, 0, 1, 0, 0, nw, dc);
    s = set_word(s, 1, 5, 0, 16'h1234);
    sta_bus = s;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    collect(s, -1, 0, 0, 1, 0, 0, nw, dc);
    chk("C_done_cycle", dc, T + 1);
`ifdef LINK_STATE_CHG_ONLY_EN
    chk("C_words", nw, 1);
`else
    chk("C_words", nw, T);
`endif

    s = rand_bus();
    sta_bus = s;
    snap_req = 1'b1;
    tick();
    out_ready = 1'b1;
    tick();
    snap_req = 1'b0;
    for (int k = 0; k < 49; k++) tick();
`ifndef LINK_STATE_CHG_ONLY_EN
    chk("D_word50", {out_valid, out_ph, out_link, out_hl},
        {1'b1, 4'd1, 8'd2, 1'b1});
`endif
    chk("D_ovr_pre", ovr_cnt, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    prev_m = '0;
    chk("D_busy", busy, 0);
    chk("D_valid", out_valid, 0);
    chk("D_ovr", ovr_cnt, 0);
    chk("D_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("D_no_done", done, 0);
    end

    s = rand_bus();
    sta_bus = s;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    collect(s, -1, 0, 0, 1, 0, 0, nw, dc);
    chk("E_done_cycle", dc, T + 1);

    s = rand_bus();
    sta_bus = s;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    collect(s, 0, 300, 0, 1, 300, 0, nw, dc);
    chk("F_ovr_sat", ovr_cnt, 255);

    sta_bus2 = 32'h11223344;
    bytes2[0] = 8'h11;
    bytes2[1] = 8'h22;
    bytes2[2] = 8'h33;
    bytes2[3] = 8'h44;
    snap_req2 = 1'b1;
    tick();
    snap_req2 = 1'b0;
    out_ready2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("G_word", {out_valid2, out_ph2, out_link2, out_hl2, out_data2},
          {1'b1, 4'd0, 8'(k / 2 + 1), 1'(k % 2 == 0), bytes2[k]});
      tick();
    end
    chk("G_done", done2, 1);
    chk("G_valid_off", out_valid2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
